// File: rtl/riscv_hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_hazard_pkg
//  Description : Shared types, forwarding-select codes and compare helpers
//                for the RV32I pipeline hazard controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_hazard_pkg;

  localparam int SB_RD_W = 5;

  // EX operand source selects
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_RET   = 2'b11;

  // One in-flight instruction as seen by the scoreboard
  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               wr;
    logic               load;
  } sb_entry_t;

  // A source register depends on an entry only if that entry really writes a
  // non-zero register and the source is actually read.
  function automatic logic sb_match(input sb_entry_t          e,
                                    input logic [SB_RD_W-1:0] rs,
                                    input logic               use_rs);
    return e.valid && e.wr && (e.rd != '0) && (e.rd == rs) && use_rs;
  endfunction

  // Youngest producer wins: MEM stage, then WB, then the retired register.
  function automatic logic [1:0] fwd_pick(input logic [SB_RD_W-1:0] rs,
                                          input logic               use_rs,
                                          input sb_entry_t          mem_e,
                                          input sb_entry_t          wb_e,
                                          input sb_entry_t          ret_e);
    if (sb_match(mem_e, rs, use_rs))      return FWD_EXMEM;
    else if (sb_match(wb_e, rs, use_rs))  return FWD_MEMWB;
    else if (sb_match(ret_e, rs, use_rs)) return FWD_RET;
    return FWD_RF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Shift register of in-flight destination registers
//                (EX -> MEM -> WB [-> RET]). With
//                HAZARD_CTRL_FORWARDING_EN defined, the RET entry and the
//                EX-stage source-register tracking are also kept.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import riscv_hazard_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  sb_entry_t          push_entry,
  input  logic               bubble,
`ifdef HAZARD_CTRL_FORWARDING_EN
  input  logic [SB_RD_W-1:0] push_rs1,
  input  logic [SB_RD_W-1:0] push_rs2,
  input  logic               push_use_rs1,
  input  logic               push_use_rs2,
  output logic [SB_RD_W-1:0] ex_rs1,
  output logic [SB_RD_W-1:0] ex_rs2,
  output logic               ex_use_rs1,
  output logic               ex_use_rs2,
  output sb_entry_t          ret_entry,
`endif
  output sb_entry_t          ex_entry,
  output sb_entry_t          mem_entry,
  output sb_entry_t          wb_entry
);

  sb_entry_t r_ex;
  sb_entry_t r_mem;
  sb_entry_t r_wb;
  logic      w_push;

  // A bubble or an empty ID slot leaves EX empty
  assign w_push = push_entry.valid && !bubble;

  // Advance every entry one stage per clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_ex  <= w_push ? push_entry : '0;
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  assign ex_entry  = r_ex;
  assign mem_entry = r_mem;
  assign wb_entry  = r_wb;

`ifdef HAZARD_CTRL_FORWARDING_EN
  sb_entry_t          r_ret;
  logic [SB_RD_W-1:0] r_ex_rs1;
  logic [SB_RD_W-1:0] r_ex_rs2;
  logic               r_ex_use_rs1;
  logic               r_ex_use_rs2;

  // Retired-result slot and the EX instruction's source operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ret        <= '0;
      r_ex_rs1     <= '0;
      r_ex_rs2     <= '0;
      r_ex_use_rs1 <= 1'b0;
      r_ex_use_rs2 <= 1'b0;
    end else begin
      r_ret        <= r_wb;
      r_ex_rs1     <= w_push ? push_rs1 : '0;
      r_ex_rs2     <= w_push ? push_rs2 : '0;
      r_ex_use_rs1 <= w_push && push_use_rs1;
      r_ex_use_rs2 <= w_push && push_use_rs2;
    end
  end

  assign ret_entry  = r_ret;
  assign ex_rs1     = r_ex_rs1;
  assign ex_rs2     = r_ex_rs2;
  assign ex_use_rs1 = r_ex_use_rs1;
  assign ex_use_rs2 = r_ex_use_rs2;
`endif

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Hazard controller for the 5-stage RV32I core. Generates
//                PC/IF-ID stall, ID-EX bubble and IF-ID flush, counts data
//                hazard stall cycles. Optional feature macro:
//                HAZARD_CTRL_FORWARDING_EN (EX forwarding selects plus
//                load-use-only interlock; full EX/MEM/WB interlock otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import riscv_hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              ex_branch_taken,
  output logic              stall_if_id,
  output logic              bubble_ex,
  output logic              flush_if_id,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt
);

  sb_entry_t        w_push;
  sb_entry_t        w_ex;
  sb_entry_t        w_mem;
  sb_entry_t        w_wb;
  logic             w_hazard;
  logic             w_branch;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_push = '{valid: id_valid, rd: id_rd, wr: id_wr_en, load: id_is_load};

`ifdef HAZARD_CTRL_FORWARDING_EN
  sb_entry_t          w_ret;
  logic [SB_RD_W-1:0] w_ex_rs1;
  logic [SB_RD_W-1:0] w_ex_rs2;
  logic               w_ex_use_rs1;
  logic               w_ex_use_rs2;
  logic               w_unused;
`else
  logic               w_unused;
`endif

  hazard_scoreboard u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_entry   (w_push),
    .bubble       (bubble_ex),
`ifdef HAZARD_CTRL_FORWARDING_EN
    .push_rs1     (id_rs1),
    .push_rs2     (id_rs2),
    .push_use_rs1 (id_use_rs1),
    .push_use_rs2 (id_use_rs2),
    .ex_rs1       (w_ex_rs1),
    .ex_rs2       (w_ex_rs2),
    .ex_use_rs1   (w_ex_use_rs1),
    .ex_use_rs2   (w_ex_use_rs2),
    .ret_entry    (w_ret),
`endif
    .ex_entry     (w_ex),
    .mem_entry    (w_mem),
    .wb_entry     (w_wb)
  );

  // Data hazard detection for the instruction sitting in ID
  always_comb begin
    w_hazard = 1'b0;
`ifdef HAZARD_CTRL_FORWARDING_EN
    // Only a load in EX cannot be forwarded in time
    w_hazard = id_valid && w_ex.load &&
               (sb_match(w_ex, id_rs1, id_use_rs1) ||
                sb_match(w_ex, id_rs2, id_use_rs2));
`else
    // Register bank is read-before-write, so anything up to WB interlocks
    w_hazard = id_valid &&
               (sb_match(w_ex,  id_rs1, id_use_rs1) || sb_match(w_ex,  id_rs2, id_use_rs2) ||
                sb_match(w_mem, id_rs1, id_use_rs1) || sb_match(w_mem, id_rs2, id_use_rs2) ||
                sb_match(w_wb,  id_rs1, id_use_rs1) || sb_match(w_wb,  id_rs2, id_use_rs2));
`endif
  end

  // A taken branch only counts if a real instruction occupies EX
  assign w_branch    = ex_branch_taken && w_ex.valid;
  assign flush_if_id = w_branch;
  assign bubble_ex   = w_branch || w_hazard;
  assign stall_if_id = w_hazard && !w_branch;

  // EX operand forwarding selects
  always_comb begin
    fwd_a_sel = FWD_RF;
    fwd_b_sel = FWD_RF;
`ifdef HAZARD_CTRL_FORWARDING_EN
    if (w_ex.valid) begin
      fwd_a_sel = fwd_pick(w_ex_rs1, w_ex_use_rs1, w_mem, w_wb, w_ret);
      fwd_b_sel = fwd_pick(w_ex_rs2, w_ex_use_rs2, w_mem, w_wb, w_ret);
    end
`endif
  end

`ifdef HAZARD_CTRL_FORWARDING_EN
  assign w_unused = &{1'b0, w_mem.load, w_wb.load, w_ret.load};
`else
  assign w_unused = &{1'b0, w_ex.load, w_mem.load, w_wb.load};
`endif

  // Saturating count of cycles lost to data-hazard stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (stall_if_id && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline hazard controller for the 5-stage RV32I core.
- Sits beside the decode stage and tracks the destination register of every in-flight instruction in a scoreboard.
- Drives PC/IF-ID stall, ID-EX bubble insertion and IF-ID flush on taken branches.
- When compiled in, also generates EX operand forwarding selects, so programs no longer need hand-inserted NOPs between dependent instructions.

## Interface
- REG_AW, 5, register address width
- CNT_W, 16, stall counter width
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  instruction present in ID
- id_rs1, id_rs2  in  REG_AW  ID source registers
- id_use_rs1, id_use_rs2  in  1  source actually read (0 for LUI/JAL etc.)
- id_rd  in  REG_AW  ID destination
- id_wr_en  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- stall_if_id  out  1  hold PC and IF/ID register
- bubble_ex  out  1  load NOP into ID/EX
- flush_if_id  out  1  replace IF/ID content with NOP
- fwd_a_sel, fwd_b_sel  out  2  EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 retired-result register
- stall_cnt  out  CNT_W  saturating count of data-hazard stall cycles

## Operation
- Scoreboard has four entries: EX, MEM, WB, RET.
  - Each entry holds {valid, rd, wr, load}.
  - The EX entry additionally holds rs1/rs2/use flags.
- Every clock, entries shift EX→MEM→WB→RET.
- The EX entry loads the ID instruction when id_valid && !bubble_ex; otherwise it is invalidated.
- Match rule: a source matches an entry when the entry is valid, wr=1, rd≠0, rd==rs, and the corresponding use flag is 1.
- Data hazard, forwarding build: stall when ID matches the EX entry with load=1 (load-use). Exactly 1 stall cycle.
- Data hazard, non-forwarding build: stall when ID matches the EX, MEM or WB entry. The register bank is read-before-write, so RET never matches. An adjacent dependency costs 3 cycles.
- Stall: stall_if_id=1, bubble_ex=1.
- Branch: ex_branch_taken gated by EX entry valid gives flush_if_id=1 and bubble_ex=1 for that cycle.
- Taken-branch flush has priority over stall: stall_if_id=0, and stall_cnt does not count that cycle.
- Forwarding compares EX rs1/rs2 against MEM, then WB, then RET; the youngest match wins (01 > 10 > 11). fwd is 00 when the use flag is 0 or rs==0.
- stall_cnt increments on each stall cycle and holds at all-ones.

## Timing
- stall_if_id, bubble_ex, flush_if_id and fwd_*_sel are combinational from the scoreboard and ID/EX inputs, valid in the same cycle.
- Scoreboard update and stall_cnt are registered.
- Reset (rst=0, asynchronous):
  - All scoreboard entries are invalid and stall_cnt=0.
  - All outputs are therefore 0, including fwd_*_sel=00.
- Reset release mid-stall: the stall ends immediately, because the scoreboard is empty.
- Consecutive taken branches: each one flushes independently. A stalled ID instruction is discarded by the flush and never enters EX.
- An x0 destination never creates a hazard or a forward.

## Configuration
- Macro: HAZARD_CTRL_FORWARDING_EN.
- Defined: load-use single stall; fwd_*_sel active; RET entry used.
- Undefined:
  - fwd_*_sel tied to 00.
  - Full EX/MEM/WB interlock stalls.
  - RET entry and EX rs tracking removed.

## Structure
- Package riscv_hazard_pkg holds:
  - sb_entry_t struct {valid, rd, wr, load}.
  - FWD_RF/FWD_EXMEM/FWD_MEMWB/FWD_RET localparams (2'b00..2'b11).
- Sub-module hazard_scoreboard: the shift register of entries. It has clk/rst, a push entry and a bubble control, and exposes all entries.
- hazard_ctrl holds the compare logic, priority, forwarding muxing and the counter.

## Test plan
- Reset: hold rst=0 with ex_branch_taken=1 and id_valid=1 → all outputs 0, stall_cnt=0.
- addi x1,x0,10 then add x3,x1,x2, back-to-back:
  - Forwarding build: no stall; fwd_a_sel=01 when add is in EX.
  - Non-forwarding build: 3 stall cycles, stall_cnt=3.
- lw x18,17(x1) then add x20,x18,x9 (forwarding build) → 1 stall cycle, then fwd_a_sel=10.
- addi x0,x0,0 followed by add x5,x0,x0 → no stall, fwd 00.
- Taken beq in EX while ID is in a load-use stall → flush_if_id=1, bubble_ex=1, stall_if_id=0, stall_cnt unchanged.
- Force stall_cnt near saturation (CNT_W=4) and keep stalling → holds at 15.
